// File: rtl/uart_tx_ctrl_if.sv
// Byte-source / mux-side signal bundle for the UART transmit sequencer.
// tx_valid/tx_ready: a byte transfers on a rising edge where both are high; the source holds tx_valid and tx_data stable until then.
interface uart_tx_ctrl_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic [3:0] sel;
   logic [7:0] data_q;
   logic       mux_q;
   logic       tx;
   logic       busy;
   logic       tx_done;

   modport master (
      output tx_valid, tx_data, mux_q,
      input  tx_ready, sel, data_q, tx, busy, tx_done
   );

   modport slave (
      input  tx_valid, tx_data, mux_q,
      output tx_ready, sel, data_q, tx, busy, tx_done
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Steps the transmit bit-select mux through start, 8 data bits (LSB first) and stop bits,
// one bit per CLKS_PER_BIT clocks, and drives the serial line from the mux output.
module uart_tx_ctrl #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_ctrl_if.slave    bus,
   output logic [1:0]       dbg_state_o
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [3:0]  SEL_STOP  = 4'd9;

   state_t      state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   logic [7:0]  byte_q, byte_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic        stop_q, stop_d;
   logic        done_q, done_d;
   logic        bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= SEL_STOP;
         byte_q  <= 8'd0;
         baud_q  <= 16'd0;
         bit_q   <= 3'd0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         byte_q  <= byte_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      byte_d  = byte_q;
      baud_d  = baud_q + 16'd1;
      bit_d   = bit_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = 16'd0;
            if (bus.tx_valid) begin
               byte_d  = bus.tx_data;
               sel_d   = 4'd0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               sel_d   = 4'd1;
               bit_d   = 3'd0;
               baud_d  = 16'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = 16'd0;
               if (bit_q == 3'd7) begin
                  sel_d   = SEL_STOP;
                  stop_d  = 1'b0;
                  state_d = STOP;
               end else begin
                  sel_d = sel_q + 4'd1;
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = 16'd0;
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = SEL_STOP;
            baud_d  = 16'd0;
         end
      endcase
   end

   // The line is forced high outside start/data so the mux is never trusted for sel=9.
   assign bus.tx       = (state_q == IDLE || state_q == STOP) ? 1'b1 : bus.mux_q;
   assign bus.tx_ready = (state_q == IDLE);
   assign bus.busy     = (state_q != IDLE);
   assign bus.sel      = sel_q;
   assign bus.data_q   = byte_q;
   assign bus.tx_done  = done_q;
   assign dbg_state_o  = state_q;
endmodule
